fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into pc on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080, exception target address (used only with FETCH_CTRL_EXC_EN).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  read address; equals pc.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-009 instr_valid  output  1  instr_out/instr_pc hold a fetched instruction.
REQ-010 instr_ready  input  1  decode accepts instruction when instr_valid=1.
REQ-011 instr_out  output  32  fetched instruction word.
REQ-012 instr_pc  output  32  address of instr_out.
REQ-013 redirect  input  1  one-cycle pulse: branch taken or jump.
REQ-014 redirect_target  input  32  new pc, sampled when redirect=1.
REQ-015 exc_req  input  1  exception pulse (present only with FETCH_CTRL_EXC_EN).
REQ-016 pc  output  32  current fetch address register.

Function
REQ-017 FSM states: IDLE, REQ, HOLD; IDLE->REQ unconditionally the cycle after reset release.
REQ-018 REQ: imem_req=1, imem_addr=pc held stable until imem_ack; on ack, instr_out<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to HOLD.
REQ-019 HOLD: instr_valid=1, imem_req=0; instr_out/instr_pc stable until instr_ready=1; on instr_ready go to REQ next cycle (one bubble per instruction; throughput one per 2 cycles with zero-wait memory).
REQ-020 redirect in IDLE or HOLD: pc<=redirect_target next cycle, instr_valid deasserted next cycle, held instruction dropped, next state REQ.
REQ-021 redirect in REQ without imem_ack: target latched in pending register, request stays stable; on later ack the returned word is discarded (instr_valid stays 0), pc<=pending target, remain in REQ.
REQ-022 redirect in REQ coinciding with imem_ack: returned word discarded, pc<=redirect_target, remain in REQ.
REQ-023 Second redirect while one is pending: newest target overwrites pending target.
REQ-024 redirect and instr_ready same cycle in HOLD: redirect wins; held instruction treated as consumed, no duplicate delivery.
REQ-025 pc[1:0] forced to 2'b00 on every load; redirect_target[1:0] ignored.

Reset
REQ-026 On rst=1: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, pending redirect cleared, asynchronously.
REQ-027 Reset mid-REQ abandons the outstanding request; an imem_ack arriving after reset release while state is IDLE is ignored.

Configuration
REQ-028 Macro FETCH_CTRL_EXC_EN defined: exc_req port exists; exc_req has priority over redirect in every state, loads pc<=EXC_VECTOR, using the same drop/pending rules as REQ-020..REQ-022.
REQ-029 Macro FETCH_CTRL_EXC_EN undefined: exc_req port and EXC_VECTOR logic absent; behaviour identical to REQ-017..REQ-027.

Verification
REQ-030 Reset release, zero-wait memory returning addr as data, instr_ready=1 -> instr_pc sequence 0,4,8,12, instr_valid every other cycle.
REQ-031 imem_ack delayed 3 cycles at pc=8 -> imem_addr held at 8 for 4 cycles, instr_out=8 delivered once.
REQ-032 redirect target 32'h100 during REQ before ack at pc=4 -> word for 4 discarded, next imem_addr=32'h100, next instr_pc=32'h100.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instr_out/instr_pc constant, imem_req=0 throughout.
REQ-034 pc=32'hFFFF_FFFC fetched -> next imem_addr=0; rst asserted mid-REQ -> pc=RESET_PC, imem_req=0 same cycle.
REQ-035 With FETCH_CTRL_EXC_EN: exc_req and redirect (target 32'h200) same cycle -> next imem_addr=32'h80.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack, decode handshake and redirects.
// The exc_req wire is present only when FETCH_CTRL_EXC_EN is defined.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef FETCH_CTRL_EXC_EN
  logic        exc_req;
`endif

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
`ifdef FETCH_CTRL_EXC_EN
    , input exc_req
`endif
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
`ifdef FETCH_CTRL_EXC_EN
    , output exc_req
`endif
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with branch/jump redirect handling.
// Defining FETCH_CTRL_EXC_EN adds exc_req, which redirects to EXC_VECTOR ahead of redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef FETCH_CTRL_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus,
  output logic [31:0]  pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        redir_s;
  logic [31:0] redir_tgt_s;

  // Merge redirect sources into one request with a word-aligned target
  always_comb begin
`ifdef FETCH_CTRL_EXC_EN
    redir_s = bus.redirect | bus.exc_req;
    if (bus.exc_req) begin
      redir_tgt_s = {EXC_VECTOR[31:2], 2'b00};
    end else begin
      redir_tgt_s = {bus.redirect_target[31:2], 2'b00};
    end
`else
    redir_s     = bus.redirect;
    redir_tgt_s = {bus.redirect_target[31:2], 2'b00};
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      instr_out_q <= 32'h0000_0000;
      instr_pc_q  <= 32'h0000_0000;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir_s) begin
          pc_d = redir_tgt_s;
        end else begin
          pc_d = pc_q;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          // A redirect seen during this request makes the returned word stale
          if (redir_s) begin
            pc_d   = redir_tgt_s;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else begin
            instr_out_d = bus.imem_rdata;
            instr_pc_d  = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = HOLD;
          end
        end else if (redir_s) begin
          pend_d     = 1'b1;
          pend_tgt_d = redir_tgt_s;
        end else begin
          pend_d = pend_q;
        end
      end
      HOLD: begin
        if (redir_s) begin
          pc_d    = redir_tgt_s;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    case (state_q)
      REQ:     bus.imem_req    = 1'b1;
      HOLD:    bus.instr_valid = 1'b1;
      default: bus.imem_req    = 1'b0;
    endcase
    bus.imem_addr = pc_q;
    bus.instr_out = instr_out_q;
    bus.instr_pc  = instr_pc_q;
    pc            = pc_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; memory echoes the address as data.
// Define FETCH_CTRL_EXC_EN to also exercise the exception path.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  int          tests_run    = 0;
  int          tests_failed = 0;

  fetch_ctrl_if bus();

  fetch_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .pc  (pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory answers the current request (if enabled), then one clock passes
  task automatic cyc(input logic ack_en);
    bus.imem_ack   = ack_en & bus.imem_req;
    bus.imem_rdata = bus.imem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    check_eq({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
    check_eq({tag, "_addr"}, bus.imem_addr, addr);
    check_eq({tag, "_nvalid"}, {31'd0, bus.instr_valid}, 32'd0);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] a);
    check_eq({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
    check_eq({tag, "_nreq"}, {31'd0, bus.imem_req}, 32'd0);
    check_eq({tag, "_ipc"}, bus.instr_pc, a);
    check_eq({tag, "_iout"}, bus.instr_out, a);
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    bus.instr_ready     = 1'b1;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = 32'h0000_0000;
`ifdef FETCH_CTRL_EXC_EN
    bus.exc_req         = 1'b0;
`endif
    @(posedge clk);
    #1;
    check_eq("rst_pc", pc, 32'h0000_0000);
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_eq("rst_iout", bus.instr_out, 32'h0000_0000);
    check_eq("rst_ipc", bus.instr_pc, 32'h0000_0000);
    rst = 1'b0;
  endtask

  initial begin
    // Zero-wait streaming, then a 5-cycle decode stall
    do_reset();
    cyc(1'b1);
    for (int i = 0; i < 4; i++) begin
      check_req($sformatf("seq%0d", i), 32'(4 * i));
      cyc(1'b1);
      check_hold($sformatf("seq%0d", i), 32'(4 * i));
      if (i < 3) cyc(1'b1);
    end
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      check_hold($sformatf("stall%0d", i), 32'h0000_000C);
    end
    bus.instr_ready = 1'b1;
    cyc(1'b1);
    check_req("after_stall", 32'h0000_0010);

    // Memory wait states at pc=8
    do_reset();
    cyc(1'b1);
    check_req("w0", 32'h0000_0000);
    cyc(1'b1);
    check_hold("w0", 32'h0000_0000);
    cyc(1'b1);
    check_req("w4", 32'h0000_0004);
    cyc(1'b1);
    check_hold("w4", 32'h0000_0004);
    cyc(1'b0);
    check_req("wait1", 32'h0000_0008);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b0);
      check_req($sformatf("wait%0d", i), 32'h0000_0008);
    end
    cyc(1'b1);
    check_hold("wait_hold", 32'h0000_0008);
    cyc(1'b1);
    check_req("wait_once", 32'h0000_000C);

    // Redirect pending during a request, misaligned target bits dropped
    do_reset();
    cyc(1'b1);
    cyc(1'b1);
    check_hold("r0", 32'h0000_0000);
    cyc(1'b1);
    check_req("r4", 32'h0000_0004);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    cyc(1'b0);
    bus.redirect = 1'b0;
    check_req("pend_stable", 32'h0000_0004);
    cyc(1'b1);
    check_req("pend_discard", 32'h0000_0100);
    cyc(1'b1);
    check_hold("pend_hold", 32'h0000_0100);

    // Redirect coinciding with ack
    cyc(1'b1);
    check_req("co_req", 32'h0000_0104);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0040;
    cyc(1'b1);
    bus.redirect = 1'b0;
    check_req("co_redir", 32'h0000_0040);
    cyc(1'b1);
    check_hold("co_hold", 32'h0000_0040);

    // Redirect and instr_ready together in HOLD
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0300;
    cyc(1'b1);
    bus.redirect = 1'b0;
    check_req("hold_redir", 32'h0000_0300);
    cyc(1'b1);
    check_hold("hold_redir", 32'h0000_0300);

    // Two redirects while pending: newest wins
    cyc(1'b1);
    check_req("dbl_req", 32'h0000_0304);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0500;
    cyc(1'b0);
    bus.redirect_target = 32'h0000_0600;
    cyc(1'b0);
    bus.redirect = 1'b0;
    check_req("dbl_stable", 32'h0000_0304);
    cyc(1'b1);
    check_req("dbl_new", 32'h0000_0600);
    cyc(1'b1);
    check_hold("dbl_hold", 32'h0000_0600);

    // Asynchronous reset in the middle of a request
    cyc(1'b1);
    check_req("mid_req", 32'h0000_0604);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_pc", pc, 32'h0000_0000);
    check_eq("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_req("idle_ack_ignored", 32'h0000_0000);

    // PC wrap from the top of the address space
    cyc(1'b1);
    check_hold("wr0", 32'h0000_0000);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFE;
    cyc(1'b1);
    bus.redirect = 1'b0;
    check_req("wrap_top", 32'hFFFF_FFFC);
    cyc(1'b1);
    check_hold("wrap_top", 32'hFFFF_FFFC);
    cyc(1'b1);
    check_req("wrap_zero", 32'h0000_0000);

`ifdef FETCH_CTRL_EXC_EN
    // Exception beats a simultaneous redirect
    cyc(1'b1);
    check_hold("ex0", 32'h0000_0000);
    bus.exc_req         = 1'b1;
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    cyc(1'b1);
    bus.exc_req  = 1'b0;
    bus.redirect = 1'b0;
    check_req("exc_vec", 32'h0000_0080);
    cyc(1'b1);
    check_hold("exc_hold", 32'h0000_0080);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
